// File: rtl/ocr_sequencer.sv
// OCR top-level sequencer: takes command/pixel bytes, fills the image buffer, runs the BNN, latches the digit.
// Optional inference watchdog is built when OCR_SEQ_WATCHDOG_EN is defined.
module ocr_sequencer #(
    parameter int          IMG_BYTES     = 113,
    parameter int          ADDR_W        = 7,
    parameter logic [7:0]  CMD_IMAGE     = 8'hA5,
    parameter logic [7:0]  CMD_CLEAR     = 8'hC3,
    parameter int          INFER_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        spi_rx_data,
    input  logic              spi_byte_valid,
    output logic              byte_taken,
    output logic              spi_rx_enable,
    output logic              buffer_write_en,
    output logic [ADDR_W-1:0] buffer_write_addr,
    output logic [7:0]        buffer_write_data,
    output logic              clear_buffer,
    output logic              clear_internal,
    output logic              bnn_enable,
    input  logic              result_ready,
    input  logic [3:0]        result_out,
    output logic [3:0]        result_digit,
    output logic [3:0]        status_code_reg
);

    // State encoding doubles as the reported status code.
    typedef enum logic [3:0] {
        IDLE        = 4'h0,
        RX_IMAGE    = 4'h1,
        INFER       = 4'h2,
        DONE        = 4'h3,
        ERR_TIMEOUT = 4'hE,
        ERR_CMD     = 4'hF
    } state_t;

    state_t            state, next_state;
    logic [ADDR_W-1:0] wr_ptr, wr_ptr_d;
    logic              accept, last_write, wd_expired;
    logic              write_d, clear_buf_d, clear_int_d;
    logic [3:0]        digit_d;

    assign accept          = spi_byte_valid && !byte_taken && (state != INFER);
    assign last_write      = buffer_write_en && (buffer_write_addr == ADDR_W'(IMG_BYTES - 1));
    assign status_code_reg = state;

`ifdef OCR_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(INFER_TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state == INFER)
            wd_cnt <= wd_cnt + 1'b1;
        else
            wd_cnt <= '0;
    end

    assign wd_expired = (wd_cnt == WD_W'(INFER_TIMEOUT - 1));
`else
    assign wd_expired = 1'b0;
`endif

    always_comb begin
        next_state  = state;
        wr_ptr_d    = wr_ptr;
        write_d     = 1'b0;
        clear_buf_d = 1'b0;
        clear_int_d = 1'b0;
        digit_d     = result_digit;
        case (state)
            RX_IMAGE: begin
                // Leave only once the final byte has actually been strobed into the buffer.
                if (last_write) begin
                    next_state = INFER;
                end else if (accept) begin
                    write_d  = 1'b1;
                    wr_ptr_d = wr_ptr + 1'b1;
                end
            end
            INFER: begin
                if (result_ready) begin
                    next_state = DONE;
                    digit_d    = result_out;
                end else if (wd_expired) begin
                    next_state  = ERR_TIMEOUT;
                    clear_int_d = 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    if (spi_rx_data == CMD_IMAGE) begin
                        next_state = RX_IMAGE;
                        wr_ptr_d   = '0;
                    end else if (spi_rx_data == CMD_CLEAR) begin
                        next_state  = IDLE;
                        clear_buf_d = 1'b1;
                        clear_int_d = 1'b1;
                        digit_d     = 4'h0;
                    end else begin
                        next_state = ERR_CMD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            wr_ptr            <= '0;
            byte_taken        <= 1'b0;
            buffer_write_en   <= 1'b0;
            buffer_write_addr <= '0;
            buffer_write_data <= 8'h00;
            clear_buffer      <= 1'b0;
            clear_internal    <= 1'b0;
            result_digit      <= 4'h0;
            bnn_enable        <= 1'b0;
            spi_rx_enable     <= 1'b0;
        end else begin
            state           <= next_state;
            wr_ptr          <= wr_ptr_d;
            byte_taken      <= accept;
            buffer_write_en <= write_d;
            if (write_d) begin
                buffer_write_addr <= wr_ptr;
                buffer_write_data <= spi_rx_data;
            end
            clear_buffer    <= clear_buf_d;
            clear_internal  <= clear_int_d;
            result_digit    <= digit_d;
            bnn_enable      <= (next_state == INFER);
            spi_rx_enable   <= (next_state != INFER);
        end
    end

endmodule
